// File: rtl/ball_collision_detector.sv
// Per-pixel ball/object overlap detector: accumulates hits over a frame and reports them at the frame boundary.
// Optional per-frame overlap pixel counter enabled by defining COLLISION_COUNT_EN.
module ball_collision_detector #(
    parameter int HOLDOFF_FRAMES = 3,
    parameter int COORD_W        = 11
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               drawBall,
    input  logic               drawFlipper,
    input  logic               drawObstacle,
    input  logic               drawSpring,
    input  logic               drawBumper,
    output logic               collisionFlipper,
    output logic               collisionObstacle,
    output logic               collisionSpring,
    output logic               collisionBumper,
    output logic               anyCollision,
    output logic [2:0]         collisionCode,
    output logic [COORD_W-1:0] hitX,
    output logic [COORD_W-1:0] hitY,
    output logic [15:0]        collisionPixelCount
);

    typedef enum logic {WAIT_SOF, SCAN} state_t;

    localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLDOFF_FRAMES);

    state_t             state, state_next;
    logic [3:0]         hit;          // bit 0 flipper, 1 obstacle, 2 spring, 3 bumper
    logic [3:0]         sticky;
    logic [3:0]         suppressed;
    logic [3:0]         fire;
    logic [3:0]         pulse_q;
    logic [3:0]         cap_type;     // one-hot type captured at the first hit
    logic               cap_valid;
    logic [COORD_W-1:0] cap_x, cap_y;
    logic [HW-1:0]      holdoff [4];
    logic [2:0]         report_code;
    logic               boundary;
    logic               scanning;

    function automatic logic [2:0] prio_code(input logic [3:0] v);
        if (v[0])      return 3'd1;
        else if (v[1]) return 3'd2;
        else if (v[2]) return 3'd3;
        else if (v[3]) return 3'd4;
        else           return 3'd0;
    endfunction

    assign hit      = {4{drawBall}} & {drawBumper, drawSpring, drawObstacle, drawFlipper};
    assign scanning = (state == SCAN);
    assign boundary = scanning & startOfFrame;

    always_ff @(posedge clk) begin
        if (!resetN) state <= WAIT_SOF;
        else         state <= state_next;
    end

    // NOTE: every signal written in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SOF: if (startOfFrame) state_next = SCAN;
            SCAN:     state_next = SCAN;
            default:  state_next = WAIT_SOF;
        endcase
    end

    always_comb begin
        suppressed = '0;
        for (int t = 0; t < 4; t++) suppressed[t] = (holdoff[t] != '0);
        fire = sticky & ~suppressed;
        // A suppressed captured type falls back to the best type actually reported.
        report_code = (|(cap_type & fire)) ? prio_code(cap_type) : prio_code(fire);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            // NOTE: the small hold-off array is reset element by element; it is control state, not bulk storage.
            for (int t = 0; t < 4; t++) holdoff[t] <= '0;
            sticky        <= '0;
            pulse_q       <= '0;
            cap_type      <= '0;
            cap_valid     <= 1'b0;
            cap_x         <= '0;
            cap_y         <= '0;
            collisionCode <= '0;
            hitX          <= '0;
            hitY          <= '0;
        end else begin
            pulse_q <= boundary ? fire : 4'b0000;

            if (boundary) begin
                for (int t = 0; t < 4; t++) begin
                    if (fire[t])                 holdoff[t] <= HOLD_RELOAD;
                    else if (holdoff[t] != '0)   holdoff[t] <= holdoff[t] - 1'b1;
                end
                if (|fire) begin
                    collisionCode <= report_code;
                    hitX          <= cap_x;
                    hitY          <= cap_y;
                end
            end

            // The startOfFrame cycle's pixel is the first pixel of the new frame.
            if (startOfFrame) begin
                sticky    <= hit;
                cap_valid <= |hit;
                if (|hit) begin
                    cap_type <= hit & (~hit + 4'd1);
                    cap_x    <= pixelX;
                    cap_y    <= pixelY;
                end
            end else if (scanning) begin
                sticky <= sticky | hit;
                if (!cap_valid && (|hit)) begin
                    cap_valid <= 1'b1;
                    cap_type  <= hit & (~hit + 4'd1);
                    cap_x     <= pixelX;
                    cap_y     <= pixelY;
                end
            end
        end
    end

    assign collisionFlipper  = pulse_q[0];
    assign collisionObstacle = pulse_q[1];
    assign collisionSpring   = pulse_q[2];
    assign collisionBumper   = pulse_q[3];
    assign anyCollision      = |pulse_q;

`ifdef COLLISION_COUNT_EN
    logic [15:0] pix_cnt;
    logic [15:0] cnt_out;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pix_cnt <= '0;
            cnt_out <= '0;
        end else begin
            if (boundary) cnt_out <= pix_cnt;
            if (startOfFrame)
                pix_cnt <= {15'd0, |hit};
            else if (scanning && (|hit) && (pix_cnt != 16'hFFFF))
                pix_cnt <= pix_cnt + 16'd1;
        end
    end

    assign collisionPixelCount = cnt_out;
`else
    assign collisionPixelCount = 16'd0;
`endif

endmodule

// File: tb/tb_ball_collision_detector.sv
// Scoreboard bench for ball_collision_detector: each driven startOfFrame pushes the expected report,
// which a negedge monitor pops and compares one cycle later.
module tb_ball_collision_detector;

    localparam int COORD_W = 11;

    typedef struct {
        logic [3:0]         pulses;
        logic [2:0]         code;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [15:0]        cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic [COORD_W-1:0] pixelX, pixelY;
    logic               drawBall, drawFlipper, drawObstacle, drawSpring, drawBumper;
    logic               collisionFlipper, collisionObstacle, collisionSpring, collisionBumper;
    logic               anyCollision;
    logic [2:0]         collisionCode;
    logic [COORD_W-1:0] hitX, hitY;
    logic [15:0]        collisionPixelCount;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t e;
    logic sof_q = 1'b0;

    ball_collision_detector #(.HOLDOFF_FRAMES(3), .COORD_W(COORD_W)) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .pixelX              (pixelX),
        .pixelY              (pixelY),
        .drawBall            (drawBall),
        .drawFlipper         (drawFlipper),
        .drawObstacle        (drawObstacle),
        .drawSpring          (drawSpring),
        .drawBumper          (drawBumper),
        .collisionFlipper    (collisionFlipper),
        .collisionObstacle   (collisionObstacle),
        .collisionSpring     (collisionSpring),
        .collisionBumper     (collisionBumper),
        .anyCollision        (anyCollision),
        .collisionCode       (collisionCode),
        .hitX                (hitX),
        .hitY                (hitY),
        .collisionPixelCount (collisionPixelCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef COLLISION_COUNT_EN
        return v;
`else
        return 16'd0;
`endif
    endfunction

    always @(posedge clk) sof_q <= startOfFrame;

    always @(negedge clk) begin
        if (sof_q) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulses", {collisionBumper, collisionSpring, collisionObstacle, collisionFlipper}, e.pulses);
                check("any", anyCollision, |e.pulses);
                check("code", collisionCode, e.code);
                check("hitX", hitX, e.x);
                check("hitY", hitY, e.y);
                check("count", collisionPixelCount, e.cnt);
            end
        end else begin
            check("idle_pulses", {anyCollision, collisionBumper, collisionSpring, collisionObstacle, collisionFlipper}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // f bits: 0 flipper, 1 obstacle, 2 spring, 3 bumper
    task automatic drive(input logic b, input logic [3:0] f, input int x, input int y);
        drawBall     = b;
        drawFlipper  = f[0];
        drawObstacle = f[1];
        drawSpring   = f[2];
        drawBumper   = f[3];
        pixelX       = 11'(x);
        pixelY       = 11'(y);
    endtask

    task automatic hit_cycles(input logic [3:0] f, input int x, input int y, input int n);
        drive(1'b1, f, x, y);
        repeat (n) tick();
        drive(1'b0, 4'b0000, 0, 0);
    endtask

    task automatic push(input logic [3:0] p, input logic [2:0] code, input int x, input int y, input logic [15:0] cnt);
        exp_t t;
        t.pulses = p;
        t.code   = code;
        t.x      = 11'(x);
        t.y      = 11'(y);
        t.cnt    = cnt_exp(cnt);
        sb.push_back(t);
    endtask

    task automatic boundary(input logic [3:0] p, input logic [2:0] code, input int x, input int y, input logic [15:0] cnt);
        push(p, code, x, y, cnt);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {anyCollision, collisionBumper, collisionSpring, collisionObstacle, collisionFlipper}, 0);
        check({tag, "_code"}, collisionCode, 0);
        check({tag, "_hitX"}, hitX, 0);
        check({tag, "_hitY"}, hitY, 0);
        check({tag, "_count"}, collisionPixelCount, 0);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        drive(1'b0, 4'b0000, 0, 0);
        repeat (3) tick();
        check_all_zero("reset");
        resetN = 1'b1;

        // Hits before the first startOfFrame are ignored.
        hit_cycles(4'b0001, 11, 22, 2);
        boundary(4'b0000, 3'd0, 0, 0, 16'd0);

        // Single flipper hit over three cycles.
        repeat (2) tick();
        hit_cycles(4'b0001, 100, 200, 3);
        repeat (2) tick();
        boundary(4'b0001, 3'd1, 100, 200, 16'd3);
        repeat (3) boundary(4'b0000, 3'd1, 100, 200, 16'd0);

        // Bumper first, then obstacle+flipper together.
        tick();
        hit_cycles(4'b1000, 50, 60, 1);
        hit_cycles(4'b0011, 70, 80, 1);
        tick();
        boundary(4'b1011, 3'd4, 50, 60, 16'd2);
        repeat (3) boundary(4'b0000, 3'd4, 50, 60, 16'd0);

        // Captured type suppressed: code falls back to the reported spring, coordinate kept.
        hit_cycles(4'b0001, 10, 20, 1);
        boundary(4'b0001, 3'd1, 10, 20, 16'd1);
        hit_cycles(4'b0001, 30, 40, 1);
        hit_cycles(4'b0100, 5, 6, 1);
        boundary(4'b0100, 3'd3, 30, 40, 16'd2);
        repeat (3) boundary(4'b0000, 3'd3, 30, 40, 16'd0);

        // Flipper every frame: reported after frames 1 and 5 only.
        for (int i = 0; i < 5; i++) begin
            tick();
            hit_cycles(4'b0001, 200 + i, 300 + i, 1);
            if (i == 0)      boundary(4'b0001, 3'd1, 200, 300, 16'd1);
            else if (i == 4) boundary(4'b0001, 3'd1, 204, 304, 16'd1);
            else             boundary(4'b0000, 3'd1, 200, 300, 16'd1);
        end
        repeat (3) boundary(4'b0000, 3'd1, 204, 304, 16'd0);

        // Hit on the startOfFrame cycle belongs to the new frame.
        drive(1'b1, 4'b0001, 7, 8);
        boundary(4'b0000, 3'd1, 204, 304, 16'd0);
        drive(1'b0, 4'b0000, 0, 0);
        repeat (2) tick();
        boundary(4'b0001, 3'd1, 7, 8, 16'd1);

        // Reset mid-frame after a hit discards the frame.
        hit_cycles(4'b0001, 9, 9, 2);
        resetN = 1'b0;
        repeat (2) tick();
        check_all_zero("midreset");
        resetN = 1'b1;
        boundary(4'b0000, 3'd0, 0, 0, 16'd0);
        boundary(4'b0000, 3'd0, 0, 0, 16'd0);

        // Long overlap frame saturates the pixel counter.
        hit_cycles(4'b0001, 1, 2, 65600);
        boundary(4'b0001, 3'd1, 1, 2, 16'hFFFF);

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_collision_detector.md
Name: ball_collision_detector

Overview:
- Per-pixel consumer of the same `drawX` request flags that feed the main-screen RGB priority mux; works in the opposite direction from the mux.
- The mux composes overlapping objects into one colour. This block decodes the overlaps instead: it detects pixels where the ball coincides with another object.
- Overlaps are accumulated across a video frame. At each frame boundary the block emits one-cycle collision pulses, the first-hit coordinate and a priority-coded collision type to the game-physics logic.
- Per-type hold-off counters suppress repeat reports while the ball is still inside an object.

Parameters:
- HOLDOFF_FRAMES, 3: frames a type stays suppressed after it is reported; 0 disables suppression.
- COORD_W, 11: width of pixelX/pixelY.

Ports:
- clk  in  1  system pixel clock
- resetN  in  1  reset, active-low, synchronous
- startOfFrame  in  1  one-cycle pulse marking the first pixel of a frame
- pixelX  in  COORD_W  current pixel column
- pixelY  in  COORD_W  current pixel row
- drawBall  in  1  ball covers current pixel
- drawFlipper  in  1  flipper covers current pixel
- drawObstacle  in  1  obstacle covers current pixel
- drawSpring  in  1  spring covers current pixel
- drawBumper  in  1  bumper covers current pixel
- collisionFlipper  out  1  one-cycle report pulse
- collisionObstacle  out  1  one-cycle report pulse
- collisionSpring  out  1  one-cycle report pulse
- collisionBumper  out  1  one-cycle report pulse
- anyCollision  out  1  OR of the four pulses
- collisionCode  out  3  0 none, 1 flipper, 2 obstacle, 3 spring, 4 bumper; held until next report
- hitX  out  COORD_W  first-hit column of the last reported frame; held
- hitY  out  COORD_W  first-hit row of the last reported frame; held
- collisionPixelCount  out  16  see Optional Feature

Behaviour:
- Clock and reset: single clock clk. resetN is synchronous and active-low, sampled only on posedge clk.
- Reset values:
  - All outputs 0.
  - Sticky flags, capture registers and hold-off counters 0.
  - State WAIT_SOF.
  - Reset asserted mid-frame discards the partial frame; no pulse is emitted for it.
- WAIT_SOF: draw inputs are ignored. On startOfFrame, go to SCAN; that same cycle's pixel is accumulated as the first pixel of the frame.
- SCAN, per cycle, with hitT = drawBall & drawT:
  - Set sticky[T] for every hitT.
  - On the first cycle of the frame with any hitT:
    - Capture pixelX/pixelY.
    - Capture the code of the highest-priority simultaneous type. Priority order: flipper > obstacle > spring > bumper, the same order as the screen mux.
  - Later hits never overwrite the capture.
  - drawBall without any object flag: no effect.
- Frame boundary (startOfFrame while in SCAN):
  - Next cycle (latency 1), for each T: collisionT = sticky[T] & (holdoff[T]==0). Pulses last exactly one cycle.
  - anyCollision is the OR of the four pulses.
  - If any pulse fires:
    - hitX/hitY/collisionCode load from the capture.
    - If the captured type is itself suppressed, collisionCode takes the highest-priority unsuppressed reported type, and hitX/hitY still take the captured coordinate.
  - If no pulse fires, hitX/hitY/collisionCode hold their previous values.
  - Suppressed hits are discarded, not deferred.
  - Sticky flags and capture valid clear on this boundary. Draw inputs on the startOfFrame cycle itself belong to the new frame (clear and set in the same cycle: set wins).
- Hold-off counters:
  - At each boundary, every nonzero counter decrements by 1.
  - Each type pulsed at that boundary reloads its counter to HOLDOFF_FRAMES. Reload wins over decrement.
  - With HOLDOFF_FRAMES=0, no suppression ever occurs.
  - Counter width is clog2(HOLDOFF_FRAMES+1), minimum 1.
- startOfFrame on consecutive cycles: each one is a boundary. An empty frame produces no pulse but still decrements the counters.
- No backpressure: the consumer must sample the pulses in the cycle they appear.

Optional Feature:
- Macro: COLLISION_COUNT_EN.
- When defined:
  - A 16-bit saturating counter increments on every cycle of the frame with drawBall & (any object flag).
  - The count is loaded into collisionPixelCount at the boundary report cycle and counts regardless of hold-off.
  - The counter clears at the boundary; saturation holds at 16'hFFFF.
- When undefined:
  - The port still exists and is tied to 16'd0.
  - No counter logic is instantiated.

Test Plan:
- Reset then ball over flipper at (100,200) for 3 cycles mid-frame, then startOfFrame -> cycle after: collisionFlipper=1 for exactly 1 cycle, anyCollision=1, collisionCode=1, hitX=100, hitY=200; count=3 if COLLISION_COUNT_EN.
- Same frame: ball over bumper at (50,60) first, then obstacle+flipper together at (70,80) -> collisionBumper, collisionObstacle and collisionFlipper pulse together; collisionCode=4, hitX=50, hitY=60.
- Flipper hit every frame, HOLDOFF_FRAMES=3 -> collisionFlipper pulses after frames 1 and 5 only; frames 2-4 suppressed; hitX/hitY/collisionCode held.
- Hits before the first startOfFrame after reset -> no pulse at first boundary; resetN low mid-frame after a hit -> no pulse, outputs 0.
- Flipper hit on the startOfFrame cycle itself -> no pulse at that boundary; pulse at the following boundary.
- COLLISION_COUNT_EN defined, 70000 overlap cycles in one frame -> collisionPixelCount=16'hFFFF; undefined -> always 0.
